mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_pick.sv | 30 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the two-requester memory arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W      = 64;
    localparam int DEF_DATA_W      = 64;
    localparam int DEF_TIMEOUT_CYC = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// Round-robin on contention when MEM_ARB_RR_EN is defined, else load/store priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   ls_req,
    input  owner_t last_owner,
    output logic   grant_valid,
    output owner_t grant_owner
);

    assign grant_valid = if_req | ls_req;

`ifdef MEM_ARB_RR_EN
    always_comb begin
        grant_owner = OWN_IF;
        if (if_req && ls_req) begin
            grant_owner = (last_owner == OWN_IF) ? OWN_LS : OWN_IF;
        end else if (ls_req) begin
            grant_owner = OWN_LS;
        end
    end
`else
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign grant_owner       = ls_req ? OWN_LS : OWN_IF;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store requesters onto one memory port with ack timeout.
// Optional build macro MEM_ARB_RR_EN: alternate grants on contention via last-owner flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ack,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wstrb,
    output logic                ls_ack,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    owner_t           cur_owner;
    logic [CNT_W-1:0] wait_cnt;
    logic             grant_valid;
    owner_t           grant_owner;
    owner_t           last_owner;

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .ls_req      (ls_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_IF;
        end else if (state == IDLE && grant_valid) begin
            last_owner <= grant_owner;
        end
    end
`else
    assign last_owner = OWN_IF;
`endif

    assign busy  = (state != IDLE);
    assign owner = cur_owner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cur_owner <= OWN_IF;
            wait_cnt  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ls_ack    <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            // Responses are single-cycle pulses; everything defaults back to zero.
            if_ack   <= 1'b0;
            if_err   <= 1'b0;
            if_rdata <= '0;
            ls_ack   <= 1'b0;
            ls_err   <= 1'b0;
            ls_rdata <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        state     <= BUSY;
                        cur_owner <= grant_owner;
                        wait_cnt  <= '0;
                        mem_req   <= 1'b1;
                        if (grant_owner == OWN_LS) begin
                            mem_we    <= ls_we;
                            mem_addr  <= ls_addr;
                            mem_wdata <= ls_wdata;
                            mem_wstrb <= ls_wstrb;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_wstrb <= '0;
                        end
                    end
                end
                BUSY: begin
                    // An ack arriving on the terminal-count cycle still completes normally.
                    if (mem_ack || wait_cnt == CNT_LAST) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (cur_owner == OWN_LS) begin
                            ls_ack   <= 1'b1;
                            ls_err   <= !mem_ack;
                            ls_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_err   <= !mem_ack;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
